// File: rtl/boot_mem_pkg.sv
// ============================================================================
// boot_mem_pkg : shared FSM encoding and boot constants for boot_mem.
// Rev 1.0
// ============================================================================
`default_nettype none

package boot_mem_pkg;

  // One-hot loader state, matching the core's state style.
  typedef enum logic [9:0] {
    ST_MAGIC   = 10'b00_0000_0001,
    ST_ADDR_LO = 10'b00_0000_0010,
    ST_ADDR_HI = 10'b00_0000_0100,
    ST_LEN_LO  = 10'b00_0000_1000,
    ST_LEN_HI  = 10'b00_0001_0000,
    ST_DATA    = 10'b00_0010_0000,
    ST_CSUM    = 10'b00_0100_0000,
    ST_RELEASE = 10'b00_1000_0000,
    ST_RUN     = 10'b01_0000_0000,
    ST_FAULT   = 10'b10_0000_0000
  } state_e;

  localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;
  localparam logic [15:0] RESET_VEC_LO  = 16'hFFFC;
  localparam logic [15:0] RESET_VEC_HI  = 16'hFFFD;

endpackage

`default_nettype wire

// File: rtl/boot_mem_ram.sv
// ============================================================================
// boot_mem_ram : byte array, one synchronous write port, one async read port.
// Rev 1.0
// ============================================================================
`default_nettype none

module boot_mem_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/boot_mem.sv
// ============================================================================
// boot_mem : 6502 system memory with framed byte-stream boot loader.
// Optional core write port: define BOOT_MEM_PROC_WR_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module boot_mem
  import boot_mem_pkg::*;
#(
  parameter int         MEM_ADDR_W     = 16,
  parameter int         RELEASE_CYCLES = 4,
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic [15:0] address,
`ifdef BOOT_MEM_PROC_WR_EN
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
`endif
  output logic [7:0]  rd_data,
  output logic        proc_resetn,
  output logic        busy,
  output logic        err
);

  localparam logic [7:0] REL_LAST = 8'(RELEASE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] waddr_q, waddr_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  rel_cnt_q, rel_cnt_d;
  logic        end_q, end_d;
  logic        err_q, err_d;
  logic        ld_ready_q, ld_ready_d;
  logic        proc_resetn_q, proc_resetn_d;
  logic        ld_we;

  logic        accept;
  logic [7:0]  sum_next;

  assign accept   = ld_valid & ld_ready_q;
  assign sum_next = csum_q + ld_data;

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    len_d     = len_q;
    csum_d    = csum_q;
    rel_cnt_d = rel_cnt_q;
    end_d     = end_q;
    err_d     = err_q;
    ld_we     = 1'b0;
    unique case (state_q)
      ST_MAGIC: if (accept && ld_data == MAGIC) begin
        csum_d  = '0;
        state_d = ST_ADDR_LO;
      end
      ST_ADDR_LO: if (accept) begin
        waddr_d[7:0] = ld_data;
        csum_d       = sum_next;
        state_d      = ST_ADDR_HI;
      end
      ST_ADDR_HI: if (accept) begin
        waddr_d[15:8] = ld_data;
        csum_d        = sum_next;
        state_d       = ST_LEN_LO;
      end
      ST_LEN_LO: if (accept) begin
        len_d[7:0] = ld_data;
        csum_d     = sum_next;
        state_d    = ST_LEN_HI;
      end
      ST_LEN_HI: if (accept) begin
        len_d[15:8] = ld_data;
        csum_d      = sum_next;
        end_d       = ({ld_data, len_q[7:0]} == 16'd0);
        state_d     = end_d ? ST_CSUM : ST_DATA;
      end
      ST_DATA: if (accept) begin
        ld_we   = 1'b1;
        waddr_d = waddr_q + 16'd1;
        len_d   = len_q - 16'd1;
        csum_d  = sum_next;
        if (len_q == 16'd1) state_d = ST_CSUM;
      end
      // Error is sticky across frames, so release depends on the whole load.
      ST_CSUM: if (accept) begin
        err_d = err_q | (sum_next != 8'd0);
        if (!end_q) begin
          state_d = ST_MAGIC;
        end else if (err_d) begin
          state_d = ST_FAULT;
        end else begin
          rel_cnt_d = '0;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_q == REL_LAST) state_d = ST_RUN;
        else                       rel_cnt_d = rel_cnt_q + 8'd1;
      end
      ST_RUN, ST_FAULT: ;
      default: state_d = ST_MAGIC;
    endcase
    ld_ready_d    = (state_d inside {ST_MAGIC, ST_ADDR_LO, ST_ADDR_HI, ST_LEN_LO,
                                     ST_LEN_HI, ST_DATA, ST_CSUM});
    proc_resetn_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_MAGIC;
      waddr_q       <= '0;
      len_q         <= '0;
      csum_q        <= '0;
      rel_cnt_q     <= '0;
      end_q         <= 1'b0;
      err_q         <= 1'b0;
      ld_ready_q    <= 1'b1;
      proc_resetn_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      waddr_q       <= waddr_d;
      len_q         <= len_d;
      csum_q        <= csum_d;
      rel_cnt_q     <= rel_cnt_d;
      end_q         <= end_d;
      err_q         <= err_d;
      ld_ready_q    <= ld_ready_d;
      proc_resetn_q <= proc_resetn_d;
    end
  end

  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_waddr;
  logic [7:0]            mem_wdata;

`ifdef BOOT_MEM_PROC_WR_EN
  // The loader owns the write port until the core is running.
  logic core_we;
  assign core_we   = (state_q == ST_RUN) & wr_en;
  assign mem_we    = ld_we | core_we;
  assign mem_waddr = core_we ? address[MEM_ADDR_W-1:0] : waddr_q[MEM_ADDR_W-1:0];
  assign mem_wdata = core_we ? wr_data : ld_data;
`else
  assign mem_we    = ld_we;
  assign mem_waddr = waddr_q[MEM_ADDR_W-1:0];
  assign mem_wdata = ld_data;
`endif

  boot_mem_ram #(
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (address[MEM_ADDR_W-1:0]),
    .rdata_o (rd_data)
  );

  assign ld_ready    = ld_ready_q;
  assign proc_resetn = proc_resetn_q;
  assign err         = err_q;
  assign busy        = (state_q inside {ST_ADDR_LO, ST_ADDR_HI, ST_LEN_LO,
                                        ST_LEN_HI, ST_DATA, ST_CSUM});

endmodule

`default_nettype wire

// File: tb/tb_boot_mem.sv
// ============================================================================
// tb_boot_mem : randomized frame loads checked against a frame-level memory model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_boot_mem;
  import boot_mem_pkg::*;

  localparam int REL = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready;
  logic [15:0] address = 16'h0000;
  logic [7:0]  rd_data;
  logic        proc_resetn;
  logic        busy;
  logic        err;
`ifdef BOOT_MEM_PROC_WR_EN
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
`endif

  always #5 clk = ~clk;

  boot_mem #(
    .MEM_ADDR_W     (16),
    .RELEASE_CYCLES (REL),
    .MAGIC          (8'hA5)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .address     (address),
`ifdef BOOT_MEM_PROC_WR_EN
    .wr_en       (wr_en),
    .wr_data     (wr_data),
`endif
    .rd_data     (rd_data),
    .proc_resetn (proc_resetn),
    .busy        (busy),
    .err         (err)
  );

  // Reference model: byte image of what the loader should have written.
  logic [7:0] mem_m   [0:65535];
  logic       known_m [0:65535];
  logic       err_m = 1'b0;
  logic [7:0] fdata[$];
  int         gap_mode = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gaps;
    int n;
    gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (gaps) tick();
    n = 0;
    while (!ld_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ld_ready_timeout", ld_ready, 1);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic check_mem(input logic [15:0] a);
    address = a;
    #1;
    if (known_m[a]) check($sformatf("mem[%04h]", a), rd_data, mem_m[a]);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] len, input logic [7:0] delta);
    logic [7:0]  sum;
    logic [15:0] wa;
    sum = a[7:0] + a[15:8] + len[7:0] + len[15:8];
    foreach (fdata[i]) sum += fdata[i];
    send_byte(8'hA5);
    check("busy_in_frame", busy, 1);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (fdata[i]) begin
      send_byte(fdata[i]);
      wa = a + 16'(i);
      mem_m[wa]   = fdata[i];
      known_m[wa] = 1'b1;
    end
    send_byte(8'(8'h00 - sum) + delta);
    if (delta != 8'h00) err_m = 1'b1;
    check("err_after_csum", err, err_m);
    if (len != 16'd0) begin
      check("busy_after_csum", busy, 0);
      check("ready_after_csum", ld_ready, 1);
    end
  endtask

  task automatic load_random(input logic [15:0] a, input int len);
    fdata.delete();
    for (int i = 0; i < len; i++) fdata.push_back(8'($urandom));
    send_frame(a, 16'(len), 8'h00);
    for (int i = 0; i < len; i++) check_mem(a + 16'(i));
  endtask

  task automatic end_frame();
    int  low;
    logic seen;
    fdata.delete();
    send_frame(16'h0000, 16'h0000, 8'h00);
    check("ready_after_end", ld_ready, 0);
    check("busy_after_end", busy, 0);
    if (!err_m) begin
      low = 0;
      while (!proc_resetn && low < 50) begin
        low++;
        tick();
      end
      check("release_low_cycles", low, REL);
      check("proc_resetn_run", proc_resetn, 1);
      check("ready_in_run", ld_ready, 0);
    end else begin
      seen = 1'b0;
      repeat (120) begin
        tick();
        if (proc_resetn) seen = 1'b1;
      end
      check("fault_holds_reset", seen, 0);
      check("fault_err", err, 1);
      check("fault_ready", ld_ready, 0);
    end
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    ld_valid = 1'b0;
    tick();
    resetn = 1'b1;
    err_m  = 1'b0;
    check("rst_proc_resetn", proc_resetn, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] b0;
    for (int i = 0; i < 65536; i++) known_m[i] = 1'b0;
    repeat (3) tick();
    do_reset();

    // Leading junk is discarded, then the reset-vector frame.
    send_byte(8'h00);
    send_byte(8'h13);
    check("busy_after_junk", busy, 0);
    fdata = '{8'h00, 8'h80, 8'hEA};
    send_frame(RESET_VEC_LO, 16'd3, 8'h00);
    for (int i = 0; i < 3; i++) check_mem(RESET_VEC_LO + 16'(i));

`ifdef BOOT_MEM_PROC_WR_EN
    fdata = '{8'h77};
    send_frame(16'h0300, 16'd1, 8'h00);
    wr_en = 1'b1;
    wr_data = 8'hFF;
    address = 16'h0300;
`endif
    gap_mode = 2;
    for (int f = 0; f < 6; f++)
      load_random(16'($urandom_range(16'h1000, 16'h1F00)), int'($urandom_range(1, 8)));
`ifdef BOOT_MEM_PROC_WR_EN
    wr_en = 1'b0;
    check_mem(16'h0300);
`endif

    // One idle cycle between every byte.
    gap_mode = 1;
    load_random(16'h2000, 5);
    gap_mode = 0;

    fdata = '{8'h11, 8'h22};
    send_frame(16'hFFFF, 16'd2, 8'h00);
    check_mem(16'hFFFF);
    check_mem(16'h0000);
    check_mem(RESET_VEC_HI);
    end_frame();

`ifdef BOOT_MEM_PROC_WR_EN
    address = 16'h0200;
    wr_data = 8'h5A;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    mem_m[16'h0200] = 8'h5A;
    known_m[16'h0200] = 1'b1;
    check_mem(16'h0200);
`endif

    // Bad checksum: data still lands, release is blocked.
    do_reset();
    fdata = '{8'h31, 8'h32, 8'h33};
    send_frame(16'h4000, 16'd3, 8'h01);
    for (int i = 0; i < 3; i++) check_mem(16'h4000 + 16'(i));
    end_frame();

    // Reset mid-DATA keeps the partial write, then a clean reload releases.
    do_reset();
    gap_mode = 2;
    b0 = 8'($urandom);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h50);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(b0);
    mem_m[16'h5000] = b0;
    known_m[16'h5000] = 1'b1;
    check("busy_mid_data", busy, 1);
    do_reset();
    check_mem(16'h5000);
    load_random(16'h5000, 4);
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
